// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/stall sequencer: load-type NOP,
// sequencer states, default mul/div latency and the control-bundle layout.
package hazard_stall_ctrl_pkg;

  localparam logic [2:0] DMRd_NOP   = 3'd0;
  localparam int         MD_LAT_DEF = 4;

  typedef enum logic [0:0] {
    HZ_IDLE    = 1'b0,
    HZ_MD_BUSY = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic pc_wr;
    logic ifid_wr;
    logic idexe_wr;
    logic ifid_flush;
    logic idexe_flush;
    logic exemem_flush;
    logic md_busy;
    logic md_done;
  } hz_ctrl_t;

  // Free-running pipeline: every register written, nothing squashed.
  function automatic hz_ctrl_t ctrl_default();
    hz_ctrl_t c;
    c = '0;
    c.pc_wr    = 1'b1;
    c.ifid_wr  = 1'b1;
    c.idexe_wr = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/md_latency_counter.sv
// Down-counter for the mul/div occupancy window: load, decrement, zero-detect.
module md_latency_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard sequencer: mul/div window > taken branch > load-use > jump.
// Define HAZ_STATS_EN to add saturating stall_cnt / flush_cnt outputs.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W  = 5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  IFID_rs,
  input  logic [4:0]  IFID_rt,
  input  logic        IFID_use_rs,
  input  logic        IFID_use_rt,
  input  logic        IFID_jump,
  input  logic [2:0]  IDEXE_DMRd,
  input  logic [4:0]  IDEXE_rd,
  input  logic        IDEXE_md_start,
  input  logic        EXE_br_taken,
  output logic        PC_Wr,
  output logic        IFID_Wr,
  output logic        IDEXE_Wr,
  output logic        IFID_flush,
  output logic        IDEXE_flush,
  output logic        EXEMEM_flush,
  output logic        md_busy,
  output logic        md_done,
  output hz_state_t   o_dbg_state
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  // Entry cycle is stall cycle 1, so the counter covers the remaining MD_LAT-1.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'((MD_LAT >= 2) ? (MD_LAT - 2) : 0);

  hz_state_t r_state;
  hz_state_t w_state_nxt;
  hz_ctrl_t  w_ctrl;
  logic      w_load;
  logic      w_dec;
  logic      w_cnt_zero;
  logic      w_load_use;

  md_latency_counter #(.CNT_W(CNT_W)) u_md_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (w_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_dec),
    .o_zero     (w_cnt_zero)
  );

  assign w_load_use = (IDEXE_DMRd != DMRd_NOP) && (IDEXE_rd != 5'd0) &&
                      (((IDEXE_rd == IFID_rs) && IFID_use_rs) ||
                       ((IDEXE_rd == IFID_rt) && IFID_use_rt));

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= HZ_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_ctrl      = ctrl_default();
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    if (!rstn) begin
      w_state_nxt = HZ_IDLE;
    end else if ((r_state == HZ_MD_BUSY) || IDEXE_md_start) begin
      w_ctrl.pc_wr        = 1'b0;
      w_ctrl.ifid_wr      = 1'b0;
      w_ctrl.idexe_wr     = 1'b0;
      w_ctrl.exemem_flush = 1'b1;
      w_ctrl.md_busy      = 1'b1;
      if (r_state == HZ_MD_BUSY) begin
        w_dec = 1'b1;
        if (w_cnt_zero) begin
          w_ctrl.md_done = 1'b1;
          w_state_nxt    = HZ_IDLE;
        end
      end else if (MD_LAT == 1) begin
        w_ctrl.md_done = 1'b1;
      end else begin
        w_load      = 1'b1;
        w_state_nxt = HZ_MD_BUSY;
      end
    end else if (EXE_br_taken) begin
      w_ctrl.ifid_flush  = 1'b1;
      w_ctrl.idexe_flush = 1'b1;
    end else if (w_load_use) begin
      w_ctrl.pc_wr       = 1'b0;
      w_ctrl.ifid_wr     = 1'b0;
      w_ctrl.idexe_flush = 1'b1;
    end else if (IFID_jump) begin
      w_ctrl.ifid_flush = 1'b1;
    end
  end

  assign PC_Wr        = w_ctrl.pc_wr;
  assign IFID_Wr      = w_ctrl.ifid_wr;
  assign IDEXE_Wr     = w_ctrl.idexe_wr;
  assign IFID_flush   = w_ctrl.ifid_flush;
  assign IDEXE_flush  = w_ctrl.idexe_flush;
  assign EXEMEM_flush = w_ctrl.exemem_flush;
  assign md_busy      = w_ctrl.md_busy;
  assign md_done      = w_ctrl.md_done;
  assign o_dbg_state  = r_state;

`ifdef HAZ_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_ctrl.pc_wr && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_ctrl.ifid_flush && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (MD_LAT=4 and MD_LAT=1) share
// directed stimulus; a cycle-level model plus literal pins check both.
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  localparam int LAT0 = 4;
  localparam int LAT1 = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [4:0] ifid_rs, ifid_rt, idexe_rd;
  logic       use_rs, use_rt, jump, md_start, br_taken;
  logic [2:0] dmrd;

  logic pc0, ifw0, idw0, iff0, idf0, exf0, busy0, done0;
  logic pc1, ifw1, idw1, iff1, idf1, exf1, busy1, done1;
  hz_state_t dbg0, dbg1;
`ifdef HAZ_STATS_EN
  logic [31:0] stall0, flush0, stall1, flush1;
`endif

  hazard_stall_ctrl #(.MD_LAT(LAT0), .CNT_W(5)) dut0 (
    .clk(clk), .rstn(rstn), .IFID_rs(ifid_rs), .IFID_rt(ifid_rt),
    .IFID_use_rs(use_rs), .IFID_use_rt(use_rt), .IFID_jump(jump),
    .IDEXE_DMRd(dmrd), .IDEXE_rd(idexe_rd), .IDEXE_md_start(md_start),
    .EXE_br_taken(br_taken), .PC_Wr(pc0), .IFID_Wr(ifw0), .IDEXE_Wr(idw0),
    .IFID_flush(iff0), .IDEXE_flush(idf0), .EXEMEM_flush(exf0),
    .md_busy(busy0), .md_done(done0), .o_dbg_state(dbg0)
`ifdef HAZ_STATS_EN
    , .stall_cnt(stall0), .flush_cnt(flush0)
`endif
  );

  hazard_stall_ctrl #(.MD_LAT(LAT1), .CNT_W(5)) dut1 (
    .clk(clk), .rstn(rstn), .IFID_rs(ifid_rs), .IFID_rt(ifid_rt),
    .IFID_use_rs(use_rs), .IFID_use_rt(use_rt), .IFID_jump(jump),
    .IDEXE_DMRd(dmrd), .IDEXE_rd(idexe_rd), .IDEXE_md_start(md_start),
    .EXE_br_taken(br_taken), .PC_Wr(pc1), .IFID_Wr(ifw1), .IDEXE_Wr(idw1),
    .IFID_flush(iff1), .IDEXE_flush(idf1), .EXEMEM_flush(exf1),
    .md_busy(busy1), .md_done(done1), .o_dbg_state(dbg1)
`ifdef HAZ_STATS_EN
    , .stall_cnt(stall1), .flush_cnt(flush1)
`endif
  );

  wire [7:0] act0 = {pc0, ifw0, idw0, iff0, idf0, exf0, busy0, done0};
  wire [7:0] act1 = {pc1, ifw1, idw1, iff1, idf1, exf1, busy1, done1};

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: rem = stall cycles still owed to the current mul/div op.
  function automatic logic [7:0] model_out(input int lat, input int rem);
    logic lu;
    if (!rstn) return 8'b1110_0000;
    if ((rem > 0) || md_start)
      return {6'b000_001, 1'b1, (rem > 0) ? (rem == 1) : (lat == 1)};
    lu = (dmrd != 3'd0) && (idexe_rd != 5'd0) &&
         (((idexe_rd == ifid_rs) && use_rs) || ((idexe_rd == ifid_rt) && use_rt));
    if (br_taken) return 8'b1111_1000;
    if (lu)       return 8'b0010_1000;
    if (jump)     return 8'b1111_0000;
    return 8'b1110_0000;
  endfunction

  function automatic int model_next(input int lat, input int rem);
    if (!rstn)   return 0;
    if (rem > 0) return rem - 1;
    if (md_start) return lat - 1;
    return 0;
  endfunction

  int rem0 = 0;
  int rem1 = 0;
  logic [31:0] m_stall0 = 0, m_flush0 = 0, m_stall1 = 0, m_flush1 = 0;
  string nm[8] = '{"PC_Wr", "IFID_Wr", "IDEXE_Wr", "IFID_flush",
                   "IDEXE_flush", "EXEMEM_flush", "md_busy", "md_done"};

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) return v + 32'd1;
    return v;
  endfunction

  // Compare on the falling edge; advance the model on the rising edge.
  always begin
    logic [7:0] e0, e1;
    @(negedge clk);
    e0 = model_out(LAT0, rem0);
    e1 = model_out(LAT1, rem1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lat4 %s", nm[i]), 32'(act0[7-i]), 32'(e0[7-i]));
      chk($sformatf("lat1 %s", nm[i]), 32'(act1[7-i]), 32'(e1[7-i]));
    end
    chk("lat4 state", 32'(dbg0), (rem0 > 0) ? 32'd1 : 32'd0);
    chk("lat1 state", 32'(dbg1), (rem1 > 0) ? 32'd1 : 32'd0);
`ifdef HAZ_STATS_EN
    chk("lat4 stall_cnt", stall0, m_stall0);
    chk("lat4 flush_cnt", flush0, m_flush0);
    chk("lat1 stall_cnt", stall1, m_stall1);
    chk("lat1 flush_cnt", flush1, m_flush1);
`endif
    @(posedge clk);
    e0 = model_out(LAT0, rem0);
    e1 = model_out(LAT1, rem1);
    if (!rstn) begin
      m_stall0 = 0; m_flush0 = 0; m_stall1 = 0; m_flush1 = 0;
    end else begin
      m_stall0 = sat_inc(m_stall0, !e0[7]);
      m_flush0 = sat_inc(m_flush0, e0[4]);
      m_stall1 = sat_inc(m_stall1, !e1[7]);
      m_flush1 = sat_inc(m_flush1, e1[4]);
    end
    rem0 = model_next(LAT0, rem0);
    rem1 = model_next(LAT1, rem1);
  end

  // ---------------- driver tasks ----------------
  task automatic clr();
    ifid_rs = 5'd0; ifid_rt = 5'd0; use_rs = 1'b0; use_rt = 1'b0;
    jump = 1'b0; dmrd = 3'd0; idexe_rd = 5'd0; md_start = 1'b0; br_taken = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs, input logic urs);
    dmrd = 3'd1; idexe_rd = rd; ifid_rs = rs; use_rs = urs;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int stalls;
    clr();
    rstn = 1'b0;
    md_start = 1'b1;
    @(negedge clk);
    chk("reset PC_Wr", 32'(pc0), 32'd1);
    chk("reset md_busy", 32'(busy0), 32'd0);
    chk("reset lat1 md_done", 32'(done1), 32'd0);
    step(); step();
    rstn = 1'b1; clr();
    @(negedge clk);
    chk("idle IDEXE_Wr", 32'(idw0), 32'd1);
`ifdef HAZ_STATS_EN
    chk("stats after reset stall", stall0, 32'd0);
    chk("stats after reset flush", flush0, 32'd0);
`endif

    // load-use on rs, then the load has moved to MEM
    step(); load_use(5'd5, 5'd5, 1'b1);
    @(negedge clk);
    chk("lu PC_Wr", 32'(pc0), 32'd0);
    chk("lu IFID_Wr", 32'(ifw0), 32'd0);
    chk("lu IDEXE_flush", 32'(idf0), 32'd1);
    step(); clr();
    @(negedge clk);
    chk("lu next PC_Wr", 32'(pc0), 32'd1);
    step(); load_use(5'd0, 5'd0, 1'b1);
    @(negedge clk);
    chk("lu r0 PC_Wr", 32'(pc0), 32'd1);
    step(); load_use(5'd5, 5'd5, 1'b0);
    @(negedge clk);
    chk("lu no use PC_Wr", 32'(pc0), 32'd1);
    step(); load_use(5'd7, 5'd3, 1'b1); ifid_rt = 5'd7; use_rt = 1'b1;
    @(negedge clk);
    chk("lu rt PC_Wr", 32'(pc0), 32'd0);

    // mul/div window; a load-use in cycle 2 must be masked
    step(); clr(); md_start = 1'b1;
    stalls = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 2) load_use(5'd5, 5'd5, 1'b1);
      if (c == 3) begin dmrd = 3'd0; idexe_rd = 5'd0; end
      if (c == 5) md_start = 1'b0;
      @(negedge clk);
      if (!pc0) stalls++;
      chk($sformatf("md c%0d md_done", c), 32'(done0), (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("md c%0d EXEMEM_flush", c), 32'(exf0), (c <= 4) ? 32'd1 : 32'd0);
      if (c == 2) chk("md masks lu IDEXE_flush", 32'(idf0), 32'd0);
      if (c == 1) chk("lat1 md_done", 32'(done1), 32'd1);
      step();
    end
    chk("md stall cycles", 32'(stalls), 32'd4);
    clr();

    // taken branch beats concurrent load-use and jump
    load_use(5'd5, 5'd5, 1'b1); jump = 1'b1; br_taken = 1'b1;
    @(negedge clk);
    chk("br IFID_flush", 32'(iff0), 32'd1);
    chk("br IDEXE_flush", 32'(idf0), 32'd1);
    chk("br PC_Wr", 32'(pc0), 32'd1);
    chk("br IFID_Wr", 32'(ifw0), 32'd1);
    step(); clr();
    @(negedge clk);
    chk("br next IFID_flush", 32'(iff0), 32'd0);

    // plain jump, then jump held by a load-use stall
    step(); jump = 1'b1;
    @(negedge clk);
    chk("jump IFID_flush", 32'(iff0), 32'd1);
    step(); load_use(5'd9, 5'd9, 1'b1);
    @(negedge clk);
    chk("jump+lu IFID_flush", 32'(iff0), 32'd0);
    chk("jump+lu PC_Wr", 32'(pc0), 32'd0);
    step(); dmrd = 3'd0;
    @(negedge clk);
    chk("held jump IFID_flush", 32'(iff0), 32'd1);

    // reset during MD_BUSY cycle 2 aborts the window
    step(); clr(); md_start = 1'b1;
    @(negedge clk);
    chk("abort c1 md_busy", 32'(busy0), 32'd1);
    step(); rstn = 1'b0;
    @(negedge clk);
    chk("abort rst PC_Wr", 32'(pc0), 32'd1);
    chk("abort rst md_busy", 32'(busy0), 32'd0);
    step(); rstn = 1'b1; md_start = 1'b0;
    @(negedge clk);
    chk("abort after md_busy", 32'(busy0), 32'd0);
    chk("abort after state", 32'(dbg0), 32'd0);

    // one clean op after reset, for the statistics counters
    step(); md_start = 1'b1;
    step(); md_start = 1'b0;
    step(); step(); step();
    @(negedge clk);
    chk("post-op PC_Wr", 32'(pc0), 32'd1);
`ifdef HAZ_STATS_EN
    chk("stats lat4 stall", stall0, 32'd4);
    chk("stats lat1 stall", stall1, 32'd1);
    chk("stats lat4 flush", flush0, 32'd0);
`endif
    step(); step();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
